// File: rtl/alu_exec_if.sv
// Request/response bundle between the issue stage and alu_exec.
// Ports: start/ALU_control/A/B (request, issuer -> ALU), busy/done/result/zero (status and result, ALU -> issuer).
// master modport is the issuing side, slave modport is the ALU.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, ALU_control, A, B,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, ALU_control, A, B,
        output busy, done, result, zero
    );
endinterface

// File: rtl/alu_exec.sv
// Integer execute unit: logic/arith/shift/compare in one cycle, MUL by iterative shift-add.
// Latency: done the cycle after start for single-cycle codes, WIDTH+1 cycles after start for MUL.
// Backpressure: start is only sampled in IDLE; busy stays high through MUL and the one-cycle DONE.
// Ports: clk, reset (sync, active-high); bus (slave): start, ALU_control, A, B in; busy, done, result, zero out.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       op_code;
    logic [WIDTH-1:0] op_a;      // multiplicand, shifted left each MUL iteration
    logic [WIDTH-1:0] op_b;      // multiplier, shifted right each MUL iteration
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;
    logic             accept;
    logic             mul_exit;

    assign accept   = (state == S_IDLE) && bus.start;
    assign acc_step = acc + (op_b[0] ? op_a : '0);
    // Last iteration ends the multiply; a non-MUL latched code can never hold
    // the machine in S_MUL.
    assign mul_exit = (state == S_MUL) &&
                      ((cnt == SW'(WIDTH - 1)) || (op_code != OP_MUL));

    // Single-cycle ops are evaluated on the live operands so the result can be
    // loaded on the same edge that latches them (done follows start by one cycle).
    assign sh = bus.B[SW-1:0];

    always_comb begin
        alu_res = '0;
        unique case (bus.ALU_control)
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_ADD:  alu_res = bus.A + bus.B;
            OP_SUB:  alu_res = bus.A - bus.B;
            OP_SLL:  alu_res = bus.A << sh;
            OP_SRL:  alu_res = bus.A >> sh;
            OP_SRA:  alu_res = $signed(bus.A) >>> sh;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.ALU_control == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_exit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.busy = (state != S_IDLE);
        bus.done = (state == S_DONE);
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;

    // Operand latch, multiply datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            op_code  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (accept) begin
            op_code <= bus.ALU_control;
            op_a    <= bus.A;
            op_b    <= bus.B;
            acc     <= '0;
            cnt     <= '0;
            if (bus.ALU_control != OP_MUL) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
            end
        end else if (state == S_MUL) begin
            acc  <= acc_step;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt + 1'b1;
            // Partial products stay internal; result only changes on the final step.
            if (mul_exit) begin
                result_q <= acc_step;
                zero_q   <= (acc_step == '0);
            end
        end
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; the shift amount is the low log2(WIDTH) bits of B.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port ALU_control, input, 4 bits: operation code from the ALU decoder.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand 1 (rs1).
REQ-007 The block SHALL have port B, input, WIDTH bits: operand 2 (rs2 or immediate).
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: registered operation result.
REQ-011 The block SHALL have port zero, output, 1 bit: registered flag, high when result equals 0.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, MUL, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch ALU_control, A and B; start SHALL be ignored in MUL and DONE.
REQ-014 For any code other than 1110, the block SHALL compute the result from the latched operands, load result/zero, and enter DONE on the next edge (done high the cycle after start).
REQ-015 Code map (single-cycle): 0000 A&B; 0001 A|B; 0010 A^B; 0011 A+B; 0100 A-B; 0101 A<<sh; 0110 A>>sh logical; 0111 A>>>sh arithmetic; 1000 unsigned A<B (result 1/0); 1001 signed A<B (result 1/0).
REQ-016 Codes 1010-1101 and 1111 SHALL produce result 0 with zero=1, using single-cycle timing.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; carry and overflow SHALL be discarded.
REQ-018 Code 1110 (MUL) SHALL enter state MUL and run a shift-add multiply, one multiplier bit per cycle, for exactly WIDTH cycles, using an iteration counter cleared on entry.
REQ-019 MUL result SHALL be the low WIDTH bits of A*B (signed and unsigned agree).
REQ-020 After the WIDTH-th MUL iteration the block SHALL load result/zero and enter DONE; done SHALL be high WIDTH+1 cycles after the start cycle.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=1, then return to IDLE.
REQ-022 result and zero SHALL hold their values from DONE until the next operation completes; intermediate MUL values SHALL NOT appear on result.
REQ-023 A start asserted in the same cycle DONE is present SHALL be ignored; it is accepted only on a later cycle in IDLE.
REQ-024 Back-to-back throughput SHALL be one single-cycle operation every 2 cycles.

Reset
REQ-025 With reset=1 at a rising edge, the block SHALL enter IDLE and clear result to 0, zero to 1, done to 0, busy to 0, the counter, and the latched operands.
REQ-026 Reset SHALL take priority over start and SHALL abort an in-progress MUL with no done pulse.
REQ-027 start held high during reset SHALL be ignored; it is accepted on the first cycle after reset deasserts if still high.

Verification
REQ-028 ADD/SUB: code 0011, A=7, B=5 -> done next cycle, result=12, zero=0; then code 0100, A=5, B=5 -> result=0, zero=1.
REQ-029 Shifts and compares: A=0x80000000, B=4: SRL -> 0x08000000, SRA -> 0xF8000000; SLT with A=-1, B=1 -> 1; SLTU with same operands -> 0.
REQ-030 MUL: A=0xFFFFFFFF, B=3 -> busy for 33 cycles, done at cycle 33, result=0xFFFFFFFD; start pulses while busy have no effect.
REQ-031 Reset during MUL at iteration 10 -> next cycle busy=0, done=0, result=0, zero=1; no done pulse follows.
REQ-032 Undefined code 1010 with A=B=0xFFFF -> result=0, zero=1, done one cycle after start.
REQ-033 Held start: start high continuously with ADD ops -> done pulses every 2 cycles; result holds between pulses.
